// File: rtl/sr_ff_scheduler_pkg.sv
// Shared constants for the SR flip-flop scheduler: FSM encoding, counter width,
// and the helper that compares the three flip-flop copies.
package sr_ff_scheduler_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_APPLY  = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_REJECT = 2'd3;

    // High when the JK, D and T copies do not all hold the same value.
    function automatic logic copies_disagree(input logic a, input logic b, input logic c);
        return (a ^ b) | (b ^ c);
    endfunction

endpackage

// File: rtl/sr_ff_scheduler_cell.sv
// One SR flip-flop built three ways (JK, D, T). The copies stay equal as long
// as S=R=1 is never presented.
module sr_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q_jk,
    output logic q_d,
    output logic q_t
);

    logic q_jk_r;
    logic q_d_r;
    logic q_t_r;
    logic jk_next_s;
    logic d_next_s;
    logic t_en_s;

    // Next-state equations for each flip-flop style.
    always_comb begin
        jk_next_s = q_jk_r;
        case ({s, r})
            2'b10:   jk_next_s = 1'b1;
            2'b01:   jk_next_s = 1'b0;
            2'b11:   jk_next_s = ~q_jk_r;
            default: jk_next_s = q_jk_r;
        endcase
        d_next_s = s | (~r & q_d_r);
        t_en_s   = (s & ~q_t_r) | (r & q_t_r);
    end

    // State registers for the three copies.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_jk_r <= 1'b0;
            q_d_r  <= 1'b0;
            q_t_r  <= 1'b0;
        end else begin
            q_jk_r <= jk_next_s;
            q_d_r  <= d_next_s;
            q_t_r  <= q_t_r ^ t_en_s;
        end
    end

    assign q_jk = q_jk_r;
    assign q_d  = q_d_r;
    assign q_t  = q_t_r;

endmodule

// File: rtl/sr_ff_scheduler.sv
// Round-robin scheduler granting NREQ requesters access to one shared SR
// flip-flop; illegal S=R=1 commands are nacked without touching the cell.
module sr_ff_scheduler
    import sr_ff_scheduler_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   cmd_s,
    input  logic [NREQ-1:0]   cmd_r,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   nack,
    output logic              q,
    output logic              fault,
    output logic              busy,
    output logic [CNT_W-1:0]  cmd_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    win_r;
    logic [NREQ-1:0]  win_oh_r;
    logic             s_lat_r;
    logic             r_lat_r;
    logic [NREQ-1:0]  ack_r;
    logic [NREQ-1:0]  nack_r;
    logic             q_r;
    logic             fault_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;

    logic             found_s;
    logic [PW-1:0]    win_s;
    logic [NREQ-1:0]  win_oh_s;
    logic [NREQ-1:0]  probe_s;
    int               idx_s;
    logic             win_set_s;
    logic             win_rst_s;
    logic             cell_s_s;
    logic             cell_r_s;
    logic             q_jk_s;
    logic             q_d_s;
    logic             q_t_s;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (i == PW'(NREQ - 1)) begin
            return '0;
        end else begin
            return i + PW'(1);
        end
    endfunction

    // Round-robin search starting at the pointer, wrapping at NREQ.
    always_comb begin
        found_s  = 1'b0;
        win_s    = '0;
        win_oh_s = '0;
        probe_s  = '0;
        idx_s    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx_s = int'(ptr_r) + i;
            if (idx_s >= NREQ) begin
                idx_s = idx_s - NREQ;
            end else begin
                idx_s = idx_s;
            end
            probe_s = NREQ'(1) << idx_s;
            if (!found_s && ((req & probe_s) != '0)) begin
                found_s  = 1'b1;
                win_s    = PW'(idx_s);
                win_oh_s = probe_s;
            end else begin
                found_s  = found_s;
            end
        end
        win_set_s = (cmd_s & win_oh_s) != '0;
        win_rst_s = (cmd_r & win_oh_s) != '0;
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!found_s) begin
                    next_state_s = ST_IDLE;
                end else if (win_set_s && win_rst_s) begin
                    next_state_s = ST_REJECT;
                end else begin
                    next_state_s = ST_APPLY;
                end
            end
            ST_APPLY:  next_state_s = ST_CHECK;
            ST_CHECK:  next_state_s = ST_IDLE;
            ST_REJECT: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // The cell sees the latched command only while in APPLY.
    always_comb begin
        if (state_r == ST_APPLY) begin
            cell_s_s = s_lat_r;
            cell_r_s = r_lat_r;
        end else begin
            cell_s_s = 1'b0;
            cell_r_s = 1'b0;
        end
    end

    sr_ff_cell u_cell (
        .clk  (clk),
        .rst  (rst),
        .s    (cell_s_s),
        .r    (cell_r_s),
        .q_jk (q_jk_s),
        .q_d  (q_d_s),
        .q_t  (q_t_s)
    );

    // FSM state, latched operands, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            win_r    <= '0;
            win_oh_r <= '0;
            s_lat_r  <= 1'b0;
            r_lat_r  <= 1'b0;
            ack_r    <= '0;
            nack_r   <= '0;
            q_r      <= 1'b0;
            fault_r  <= 1'b0;
            busy_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            ack_r   <= (next_state_s == ST_CHECK)  ? win_oh_r : '0;
            nack_r  <= (next_state_s == ST_REJECT) ? win_oh_s : '0;
            // q follows the JK copy one cycle late, so it moves on the edge leaving CHECK.
            q_r     <= q_jk_s;
            if ((state_r == ST_IDLE) && found_s) begin
                win_r    <= win_s;
                win_oh_r <= win_oh_s;
                s_lat_r  <= win_set_s;
                r_lat_r  <= win_rst_s;
            end
            if ((state_r == ST_CHECK) || (state_r == ST_REJECT)) begin
                ptr_r <= wrap_inc(win_r);
            end
            if (state_r == ST_CHECK) begin
                cnt_r   <= cnt_r + CNT_W'(1);
                fault_r <= fault_r | copies_disagree(q_jk_s, q_d_s, q_t_s);
            end
        end
    end

    assign ack     = ack_r;
    assign nack    = nack_r;
    assign q       = q_r;
    assign fault   = fault_r;
    assign busy    = busy_r;
    assign cmd_cnt = cnt_r;

endmodule

// File: tb/tb_sr_ff_scheduler.sv
// Directed plus randomized bench for sr_ff_scheduler against a behavioural
// model of round-robin grant, SR semantics, latency and the command counter.
module tb_sr_ff_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] cmd_s;
    logic [3:0] cmd_r;
    logic [3:0] ack;
    logic [3:0] nack;
    logic       q;
    logic       fault;
    logic       busy;
    logic [7:0] cmd_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] req_v;
    logic [3:0] s_v;
    logic [3:0] r_v;
    int         m_ptr;
    logic       m_q;
    int         m_cnt;

    sr_ff_scheduler #(.NREQ(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .cmd_s   (cmd_s),
        .cmd_r   (cmd_r),
        .ack     (ack),
        .nack    (nack),
        .q       (q),
        .fault   (fault),
        .busy    (busy),
        .cmd_cnt (cmd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req   = req_v;
        cmd_s = s_v;
        cmd_r = r_v;
    endtask

    // Model: first raised request at or after the pointer, modulo 4.
    function automatic int pick();
        for (int k = 0; k < 4; k++) begin
            if (req_v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic rand_cmd(input int i, input bit allow_illegal);
        int v;
        v = allow_illegal ? $urandom_range(0, 3) : $urandom_range(0, 2);
        s_v[i] = (v == 1) || (v == 3);
        r_v[i] = (v == 2) || (v == 3);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"},   32'(ack),     32'd0);
        check({tag, "_nack"},  32'(nack),    32'd0);
        check({tag, "_busy"},  32'(busy),    32'd0);
        check({tag, "_q"},     32'(q),       32'(m_q));
        check({tag, "_cnt"},   32'(cmd_cnt), 32'(m_cnt));
        check({tag, "_fault"}, 32'(fault),   32'd0);
    endtask

    // Serve one grant from the current request vector; called just after an edge with the DUT idle.
    task automatic serve(input string tag, output int w);
        w = pick();
        drive();
        @(posedge clk); #1;
        if (s_v[w] && r_v[w]) begin
            check({tag, "_nack"}, 32'(nack), 32'(1) << w);
            check({tag, "_ack0"}, 32'(ack),  32'd0);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            req_v[w] = 1'b0;
            drive();
            m_ptr = (w + 1) % 4;
            @(posedge clk); #1;
            check_idle_outputs({tag, "_post"});
        end else begin
            check({tag, "_ack0"},  32'(ack),  32'd0);
            check({tag, "_nack0"}, 32'(nack), 32'd0);
            check({tag, "_busy"},  32'(busy), 32'd1);
            @(posedge clk); #1;
            check({tag, "_ack"},   32'(ack),  32'(1) << w);
            check({tag, "_nack1"}, 32'(nack), 32'd0);
            req_v[w] = 1'b0;
            drive();
            if (s_v[w]) m_q = 1'b1;
            else if (r_v[w]) m_q = 1'b0;
            m_cnt = (m_cnt + 1) % 256;
            m_ptr = (w + 1) % 4;
            @(posedge clk); #1;
            check_idle_outputs({tag, "_post"});
        end
    endtask

    initial begin
        int w;
        int cnt_start;
        logic [3:0] fresh;

        rst = 1'b0; req_v = '0; s_v = '0; r_v = '0;
        m_ptr = 0; m_q = 1'b0; m_cnt = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("idle_noreq");

        // Single legal set on requester 2.
        req_v = 4'b0100; s_v[2] = 1'b1; r_v[2] = 1'b0;
        serve("set2", w);

        // Illegal command on requester 0.
        req_v = 4'b0001; s_v[0] = 1'b1; r_v[0] = 1'b1;
        serve("illegal0", w);

        // Hold then reset.
        req_v = 4'b0010; s_v[1] = 1'b0; r_v[1] = 1'b0;
        serve("hold1", w);
        req_v = 4'b1000; s_v[3] = 1'b0; r_v[3] = 1'b1;
        serve("reset3", w);

        // Fairness with all requesters re-raising after service.
        req_v = 4'b1111;
        for (int i = 0; i < 4; i++) rand_cmd(i, 1'b0);
        for (int g = 0; g < 5; g++) begin
            serve("fair", w);
            check("fair_order", 32'(w), 32'(g % 4));
            req_v[w] = 1'b1;
            rand_cmd(w, 1'b0);
        end

        // Reset during APPLY abandons the command; pointer restarts at 0.
        req_v = 4'b0000;
        drive();
        @(posedge clk); #1;
        req_v = 4'b0100; s_v[2] = 1'b1; r_v[2] = 1'b0;
        serve("prep", w);
        req_v = 4'b1010; s_v[1] = 1'b1; r_v[1] = 1'b0; s_v[3] = 1'b1; r_v[3] = 1'b0;
        drive();
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        m_q = 1'b0; m_cnt = 0; m_ptr = 0;
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        check_idle_outputs("midrst_hold");
        rst = 1'b1;
        serve("midrst_fresh", w);
        check("midrst_winner", 32'(w), 32'd1);
        req_v = 4'b0000;
        drive();

        // Counter wrap after 256 legal commands.
        cnt_start = m_cnt;
        for (int n = 0; n < 256; n++) begin
            w = $urandom_range(0, 3);
            req_v = 4'b0000;
            req_v[w] = 1'b1;
            rand_cmd(w, 1'b0);
            serve("wrap", w);
        end
        check("wrap_cnt", 32'(cmd_cnt), 32'(cnt_start));
        check("wrap_fault", 32'(fault), 32'd0);

        // Random mix with held requests and illegal commands.
        for (int n = 0; n < 60; n++) begin
            fresh = 4'($urandom_range(0, 15)) & ~req_v;
            for (int i = 0; i < 4; i++) begin
                if (fresh[i]) begin
                    req_v[i] = 1'b1;
                    rand_cmd(i, 1'b1);
                end
            end
            if (req_v == 4'b0000) begin
                req_v[0] = 1'b1;
                rand_cmd(0, 1'b1);
            end
            serve("rand", w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sr_ff_scheduler.md
SR_FF_SCHEDULER -- requirements
Module: sr_ff_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the SR flip-flop.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  NREQ  per-requester command request, held high until ack or nack.
REQ-005 SHALL have port cmd_s  input  NREQ  per-requester S bit, stable while its req is high.
REQ-006 SHALL have port cmd_r  input  NREQ  per-requester R bit, stable while its req is high.
REQ-007 SHALL have port ack  output  NREQ  one-hot, one-cycle pulse: command applied.
REQ-008 SHALL have port nack  output  NREQ  one-hot, one-cycle pulse: command rejected as illegal (S=R=1).
REQ-009 SHALL have port q  output  1  shared SR state (JK-based copy).
REQ-010 SHALL have port fault  output  1  sticky flag: the JK, D and T implementations disagree.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port cmd_cnt  output  8  count of acked commands.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, CHECK, REJECT.
- IDLE: stays in IDLE when req == 0.
- IDLE: when req != 0, latches the round-robin winner and its S/R.
- IDLE: S=R=1 -> REJECT; otherwise -> APPLY.
REQ-014 SHALL drive the latched S/R into the flip-flop cell only during APPLY (S=R=0 elsewhere), with the cell updating on the edge leaving APPLY; APPLY -> CHECK unconditionally.
REQ-015 SHALL, in CHECK, assert ack[winner] for that single cycle, increment cmd_cnt, and set fault if q_jk, q_d and q_t are not all equal; CHECK -> IDLE.
REQ-016 SHALL, in REJECT, assert nack[winner] for that single cycle, leave the cell and cmd_cnt unchanged; REJECT -> IDLE.
REQ-017 SHALL give latency: req seen at edge N -> ack during cycle N+2 (q updated at edge N+2), or nack during cycle N+1.
REQ-018 SHALL spend at least one IDLE cycle between grants, so a requester that drops req in the cycle after ack/nack is never re-granted.
REQ-019 SHALL arbitrate round-robin: search starts at index (last winner + 1) mod NREQ; after reset the search starts at index 0.
REQ-020 SHALL advance the pointer on both ack and nack.
REQ-021 SHALL treat S=0,R=0 as a legal hold: it is acked and counted, and q is unchanged.
REQ-022 SHALL wrap cmd_cnt from 255 to 0.
REQ-023 SHALL keep fault high until reset, and SHALL continue servicing commands while fault is high.
REQ-024 SHALL ignore req/cmd changes outside IDLE, since operands are latched.

Reset
REQ-025 SHALL, while rst=0 and regardless of state, force:
- state = IDLE, pointer = 0
- q = 0 and all three cell copies = 0
- ack = 0, nack = 0, fault = 0, busy = 0, cmd_cnt = 0
REQ-026 SHALL, on reset asserted mid-operation, abandon the pending command with no ack/nack.

Structure
REQ-027 SHALL place the state encoding (IDLE/APPLY/CHECK/REJECT) and the cmd_cnt width constant in a shared package.
REQ-028 SHALL instantiate one sub-module, sr_ff_cell (S, R, clk, rst -> q_jk, q_d, q_t), holding the JK-, D- and T-based SR flip-flops.

Verification
REQ-029 SHALL cover single legal set: rst released, req[2]=1 with S=1,R=0 -> ack[2] at cycle N+2, q=1, cmd_cnt=1, fault=0.
REQ-030 SHALL cover illegal command: req[0]=1 with S=1,R=1 -> nack[0] at N+1, no ack, q unchanged, cmd_cnt unchanged.
REQ-031 SHALL cover fairness: req=4'b1111 held (each requester re-raising req after its ack) -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-032 SHALL cover hold and reset commands: q=1, then S=0,R=0 -> ack, q=1; then S=0,R=1 -> ack, q=0.
REQ-033 SHALL cover mid-operation reset: rst=0 asserted during APPLY -> all outputs 0 immediately; after release the same req is served fresh from pointer 0.
REQ-034 SHALL cover counter wrap: 256 legal commands -> cmd_cnt returns to 0, fault stays 0.
